dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 47 ++++
 rtl/dmem_arbiter.sv | 153 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: core port, debug port and data-memory port.
// slave = arbiter side, master = requesters/memory side.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic [DATA_W-1:0] c_rdata;
    logic              core_stall;

    logic              d_req;
    logic              d_we;
    logic              d_lock;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              m_read;
    logic              m_write;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        input  d_req, d_we, d_lock, d_addr, d_wdata,
        input  m_rdata,
        output c_gnt, c_rdata, core_stall,
        output d_gnt, d_rvalid, d_rdata,
        output m_read, m_write, m_addr, m_wdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        output d_req, d_we, d_lock, d_addr, d_wdata,
        output m_rdata,
        input  c_gnt, c_rdata, core_stall,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_read, m_write, m_addr, m_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Zero-latency data-memory arbiter between the core and a debug master, with
// alternating priority and a bounded debug burst lock. Optional counters: DMEM_ARB_STATS_EN.
module dmem_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_arbiter_if.slave        bus
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]          stall_cnt,
    output logic [15:0]          dbg_cnt
`endif
);

    localparam int unsigned LOCK_W = 8;
    localparam int unsigned STAT_W = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CORE = 2'd1;
    localparam logic [1:0] ST_DBG  = 2'd2;

    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(MAX_LOCK);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              prio_dbg;
    logic              prio_nxt;
    logic [LOCK_W-1:0] lock_cnt;
    logic [LOCK_W-1:0] lock_nxt;
    logic              core_win;
    logic              dbg_win;
    logic              contended;
    logic              d_rvalid_q;
    logic [DATA_W-1:0] d_rdata_q;

    // Winner selection, next state and the combinational memory-side mux.
    always_comb begin
        core_win    = 1'b0;
        dbg_win     = 1'b0;
        contended   = 1'b0;
        state_nxt   = ST_IDLE;
        prio_nxt    = prio_dbg;
        lock_nxt    = lock_cnt;

        if (!reset) begin
            contended = bus.c_req & bus.d_req;
            if (bus.c_req && !bus.d_req) begin
                core_win = 1'b1;
            end else if (bus.d_req && !bus.c_req) begin
                dbg_win = 1'b1;
            end else if (contended) begin
                // A debug owner may keep the bus only while locked and under the cap.
                if (state == ST_DBG) begin
                    if (bus.d_lock && (lock_cnt < LOCK_MAX)) begin
                        dbg_win = 1'b1;
                    end else begin
                        core_win = 1'b1;
                    end
                end else if (prio_dbg) begin
                    dbg_win = 1'b1;
                end else begin
                    core_win = 1'b1;
                end
            end
        end

        if (core_win) begin
            state_nxt = ST_CORE;
        end else if (dbg_win) begin
            state_nxt = ST_DBG;
        end

        // Priority passes to whoever lost the contended cycle.
        if (contended) begin
            prio_nxt = core_win;
        end

        if (!bus.c_req || core_win) begin
            lock_nxt = '0;
        end else if (dbg_win && (lock_cnt < LOCK_MAX)) begin
            lock_nxt = lock_cnt + LOCK_W'(1);
        end
    end

    // Bus-facing outputs follow the winner in the same cycle.
    always_comb begin
        bus.c_gnt      = core_win;
        bus.d_gnt      = dbg_win;
        bus.core_stall = bus.c_req & ~core_win;
        bus.m_read     = (core_win & ~bus.c_we) | (dbg_win & ~bus.d_we);
        bus.m_write    = (core_win &  bus.c_we) | (dbg_win &  bus.d_we);
        bus.m_addr     = ADDR_W'(0);
        bus.m_wdata    = DATA_W'(0);
        bus.c_rdata    = DATA_W'(0);
        if (core_win) begin
            bus.m_addr  = bus.c_addr;
            bus.m_wdata = bus.c_wdata;
            bus.c_rdata = bus.m_rdata;
        end else if (dbg_win) begin
            bus.m_addr  = bus.d_addr;
            bus.m_wdata = bus.d_wdata;
        end
        bus.d_rvalid   = d_rvalid_q;
        bus.d_rdata    = d_rdata_q;
    end

    // Ownership state, priority pointer and burst-lock counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            prio_dbg <= 1'b0;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            prio_dbg <= prio_nxt;
            lock_cnt <= lock_nxt;
        end
    end

    // Debug read return: data captured at the grant edge, held until the next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_rvalid_q <= 1'b0;
            d_rdata_q  <= '0;
        end else begin
            d_rvalid_q <= dbg_win & ~bus.d_we;
            if (dbg_win && !bus.d_we) begin
                d_rdata_q <= bus.m_rdata;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    // Saturating activity counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            dbg_cnt   <= '0;
        end else begin
            if (bus.core_stall && (stall_cnt != {STAT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + STAT_W'(1);
            end
            if (dbg_win && (dbg_cnt != {STAT_W{1'b1}})) begin
                dbg_cnt <= dbg_cnt + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: per-cycle grant/strobe expectations and a
// debug read-data queue, popped by a negedge monitor.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] dbg_cnt;
`endif

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .dbg_cnt   (dbg_cnt)
`endif
    );

    // Data memory model: combinational read, write at the clock edge.
    logic [31:0] mem [0:63];
    assign bus.m_rdata = mem[bus.m_addr[7:2]];
    always @(posedge clk) if (bus.m_write) mem[bus.m_addr[7:2]] <= bus.m_wdata;

    typedef struct packed {
        logic [5:0]  fl;     // c_gnt d_gnt m_read m_write core_stall d_rvalid
        logic [31:0] addr;
        logic [31:0] wd;
        logic        chk_cr;
        logic [31:0] cr;
    } exp_t;

    exp_t        sq[$];
    logic [31:0] rq[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          step   = 0;
    bit          prev_dread = 1'b0;
    int          exp_stall = 0;
    int          exp_dbg   = 0;

    // Monitor: pops one expectation per cycle, and read data on each d_rvalid.
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] dr;
        if (sq.size() > 0) begin
            e = sq.pop_front();
            step++;
            n_chk++;
            if ({bus.c_gnt, bus.d_gnt, bus.m_read, bus.m_write, bus.core_stall, bus.d_rvalid} !== e.fl) begin
                n_fail++;
                $display("FAIL flags step %0d: got %b want %b", step,
                         {bus.c_gnt, bus.d_gnt, bus.m_read, bus.m_write, bus.core_stall, bus.d_rvalid}, e.fl);
            end
            n_chk++;
            if ({bus.m_addr, bus.m_wdata} !== {e.addr, e.wd}) begin
                n_fail++;
                $display("FAIL mem_bus step %0d: got addr %h wdata %h want addr %h wdata %h",
                         step, bus.m_addr, bus.m_wdata, e.addr, e.wd);
            end
            if (e.chk_cr) begin
                n_chk++;
                if (bus.c_rdata !== e.cr) begin
                    n_fail++;
                    $display("FAIL c_rdata step %0d: got %h want %h", step, bus.c_rdata, e.cr);
                end
            end
        end
        if (bus.d_rvalid === 1'b1) begin
            n_chk++;
            if (rq.size() == 0) begin
                n_fail++;
                $display("FAIL d_rvalid step %0d: got unexpected read return %h want none", step, bus.d_rdata);
            end else begin
                dr = rq.pop_front();
                if (bus.d_rdata !== dr) begin
                    n_fail++;
                    $display("FAIL d_rdata step %0d: got %h want %h", step, bus.d_rdata, dr);
                end
            end
        end
    end

    // Drive one cycle of stimulus and queue what the arbiter should do with it.
    task automatic drive(input bit rst, input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cwd,
                         input bit dr, input bit dw, input bit dl, input logic [31:0] da, input logic [31:0] dwd,
                         input bit ecg, input bit edg, input bit chk_cr, input logic [31:0] ecr,
                         input logic [31:0] edr);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst;
        bus.c_req = cr; bus.c_we = cw; bus.c_addr = ca; bus.c_wdata = cwd;
        bus.d_req = dr; bus.d_we = dw; bus.d_lock = dl; bus.d_addr = da; bus.d_wdata = dwd;
        e.fl     = {ecg, edg, (ecg & ~cw) | (edg & ~dw), (ecg & cw) | (edg & dw), cr & ~ecg, prev_dread};
        e.addr   = ecg ? ca  : (edg ? da  : 32'h0);
        e.wd     = ecg ? cwd : (edg ? dwd : 32'h0);
        e.chk_cr = chk_cr;
        e.cr     = ecr;
        sq.push_back(e);
        if (edg && !dw) rq.push_back(edr);
        prev_dread = edg & ~dw;
        if (rst) begin
            exp_stall = 0;
            exp_dbg   = 0;
        end else begin
            if (cr && !ecg && exp_stall < 65535) exp_stall++;
            if (edg && exp_dbg < 65535) exp_dbg++;
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 1, 32'h0, 32'h0);
    endtask

    // Reset cycle with both requesters active: no grants, core stalled.
    task automatic rst_cycle();
        drive(1, 1, 0, 32'h10, 32'h0, 1, 0, 1, 32'h20, 32'h0, 0, 0, 1, 32'h0, 32'h0);
    endtask

    // Both requesting reads (core 0x10, debug 0x20) with the given lock hint.
    task automatic both(input bit dl, input bit ecg);
        drive(0, 1, 0, 32'h10, 32'h0, 1, 0, dl, 32'h20, 32'h0, ecg, ~ecg, 1,
              ecg ? 32'hDEADBEEF : 32'h0, 32'h1234);
    endtask

    task automatic test_reset();
        rst_cycle();
        rst_cycle();
        idle();
        @(negedge clk);
        n_chk++;
        if ({bus.d_rvalid, bus.d_rdata} !== 33'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got rvalid %b rdata %h want 0 0", bus.d_rvalid, bus.d_rdata);
        end
        n_chk++;
        if ({dut.state, dut.prio_dbg, dut.lock_cnt} !== 11'h0) begin
            n_fail++;
            $display("FAIL reset_state: got state %0d prio %b lock %0d want 0 0 0",
                     dut.state, dut.prio_dbg, dut.lock_cnt);
        end
    endtask

    task automatic test_core_only();
        drive(0, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h0, 32'h0);
        drive(0, 1, 1, 32'h20, 32'h00001234, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h0, 32'h0);
        drive(0, 1, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 1, 32'hDEADBEEF, 32'h0);
        idle();
    endtask

    task automatic test_debug_read();
        drive(0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h20, 32'h0, 0, 1, 1, 32'h0, 32'h1234);
        idle();
        drive(0, 0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h24, 32'hA5A5A5A5, 0, 1, 1, 32'h0, 32'h0);
        idle();
        @(negedge clk);
        n_chk++;
        if (bus.d_rdata !== 32'h1234) begin
            n_fail++;
            $display("FAIL d_rdata_hold: got %h want %h", bus.d_rdata, 32'h1234);
        end
        drive(0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h24, 32'h0, 0, 1, 1, 32'h0, 32'hA5A5A5A5);
        idle();
    endtask

    task automatic test_contention();
        rst_cycle();
        both(0, 1);
        both(0, 0);
        both(0, 1);
        both(0, 0);
        idle();
    endtask

    task automatic test_lock();
        rst_cycle();
        both(1, 1);
        both(1, 0);
        both(1, 0);
        both(1, 0);
        both(1, 1);
        both(1, 0);
        idle();
    endtask

    task automatic test_reset_burst();
        rst_cycle();
        both(1, 1);
        both(1, 0);
        rst_cycle();
        both(1, 1);
        @(negedge clk);
        n_chk++;
        if ({dut.state, dut.lock_cnt} !== 10'h0) begin
            n_fail++;
            $display("FAIL reset_burst_state: got state %0d lock %0d want 0 0", dut.state, dut.lock_cnt);
        end
        idle();
    endtask

`ifdef DMEM_ARB_STATS_EN
    task automatic test_stats();
        rst_cycle();
        both(1, 1);
        both(1, 0);
        both(1, 0);
        both(1, 0);
        both(1, 1);
        both(1, 0);
        both(1, 0);
        idle();
        @(negedge clk);
        n_chk++;
        if ({stall_cnt, dbg_cnt} !== {16'(exp_stall), 16'(exp_dbg)} || exp_stall != 5) begin
            n_fail++;
            $display("FAIL stats: got stall %0d dbg %0d want stall %0d (5) dbg %0d",
                     stall_cnt, dbg_cnt, exp_stall, exp_dbg);
        end
    endtask
`endif

    initial begin
        bus.c_req = 0; bus.c_we = 0; bus.c_addr = '0; bus.c_wdata = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_lock = 0; bus.d_addr = '0; bus.d_wdata = '0;
        test_reset();
        test_core_only();
        test_debug_read();
        test_contention();
        test_lock();
        test_reset_burst();
`ifdef DMEM_ARB_STATS_EN
        test_stats();
`endif
        repeat (3) @(negedge clk);
        n_chk++;
        if (sq.size() != 0 || rq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d cycles and %0d reads pending want 0 0", sq.size(), rq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
